// File: rtl/mips_mc_pkg.sv
// Encodings shared by the multi-cycle MIPS controller and its ALU decoder.
// MIPS_MC_BNE_EN adds the bne opcode.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// Maps ALUOp and Funct to the 3-bit ALUControl code.
// Purely combinational, zero latency; no flow control.
module mips_mc_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised functs fall back to add so the writeback is still defined.
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALU_ADD;
                    FUNCT_SUB: alu_control_o = ALU_SUB;
                    FUNCT_AND: alu_control_o = ALU_AND;
                    FUNCT_OR:  alu_control_o = ALU_OR;
                    FUNCT_SLT: alu_control_o = ALU_SLT;
                    default:   alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS main control FSM (Moore, one state per clock); MIPS_MC_BNE_EN enables bne.
// Latency lw 5, sw/R/addi 4, beq/bne/j 3, unknown 2 cycles; no backpressure.
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       PCEn,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       ir_write, mem_write, reg_write, pc_write, branch, instr_done, branch_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        alu_op     = ALUOP_ADD;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        PCSrc      = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = SRCB_FOUR;
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here speculatively and parked in ALUOut.
                ALUSrcB = SRCB_IMM_SH2;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef MIPS_MC_BNE_EN
    assign branch_cond = (Op == OP_BNE) ? ~Zero : Zero;
`else
    assign branch_cond = Zero;
`endif

    mips_mc_alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .funct_i       (Funct),
        .alu_control_o (ALUControl)
    );

    // Enables are gated by rst_n so nothing is written while reset is held.
    assign IRWrite   = rst_n & ir_write;
    assign MemWrite  = rst_n & mem_write;
    assign RegWrite  = rst_n & reg_write;
    assign InstrDone = rst_n & instr_done;
    assign PCEn      = rst_n & (pc_write | (branch & branch_cond));

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller; expected per-cycle control words go through a scoreboard queue.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctl;
        logic       done;
    } ctl_t;

    localparam int T_RST  = 0;
    localparam int T_F    = 1;
    localparam int T_D    = 2;
    localparam int T_MA   = 3;
    localparam int T_MR   = 4;
    localparam int T_MWB  = 5;
    localparam int T_MW   = 6;
    localparam int T_EX   = 7;
    localparam int T_AWB  = 8;
    localparam int T_BR   = 9;
    localparam int T_AE   = 10;
    localparam int T_AIWB = 11;
    localparam int T_J    = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       IorD, IRWrite, MemWrite, PCEn, RegWrite, RegDst, MemtoReg, ALUSrcA, InstrDone;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;

    ctl_t got;
    ctl_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mips_mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .PCEn       (PCEn),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .InstrDone  (InstrDone)
    );

    assign got = '{iord: IorD, irwrite: IRWrite, memwrite: MemWrite, pcen: PCEn,
                   regwrite: RegWrite, regdst: RegDst, memtoreg: MemtoReg, alusrca: ALUSrcA,
                   alusrcb: ALUSrcB, pcsrc: PCSrc, aluctl: ALUControl, done: InstrDone};

    function automatic ctl_t ex(input int st, input logic [2:0] alu = 3'b010,
                                input logic pcen = 1'b0, input logic done = 1'b0);
        ctl_t c;
        c        = '0;
        c.aluctl = 3'b010;
        case (st)
            T_RST:  c.alusrcb = 2'b01;
            T_F:    begin c.irwrite = 1'b1; c.pcen = 1'b1; c.alusrcb = 2'b01; end
            T_D:    begin c.alusrcb = 2'b11; c.done = done; end
            T_MA:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            T_MR:   c.iord = 1'b1;
            T_MWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
            T_MW:   begin c.iord = 1'b1; c.memwrite = 1'b1; c.done = 1'b1; end
            T_EX:   begin c.alusrca = 1'b1; c.aluctl = alu; end
            T_AWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
            T_BR:   begin c.alusrca = 1'b1; c.aluctl = 3'b110; c.pcsrc = 2'b01;
                          c.pcen = pcen; c.done = 1'b1; end
            T_AE:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            T_AIWB: begin c.regwrite = 1'b1; c.done = 1'b1; end
            T_J:    begin c.pcsrc = 2'b10; c.pcen = 1'b1; c.done = 1'b1; end
            default: c = 'x;
        endcase
        return c;
    endfunction

    // Queue the expected word, sample mid-cycle, then step to just after the next edge.
    task automatic cyc(input string tag, input ctl_t e);
        ctl_t exp_v;
        exp_q.push_back(e);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Op    = op;
        Funct = fn;
        Zero  = z;
    endtask

    logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] aluexp [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        rst_n = 1'b0;
        set_in(6'b100011, 6'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("reset_hold", ex(T_RST));
        rst_n = 1'b1;

        // lw
        cyc("lw_fetch", ex(T_F));
        cyc("lw_decode", ex(T_D));
        cyc("lw_memadr", ex(T_MA));
        cyc("lw_memrd", ex(T_MR));
        cyc("lw_memwb", ex(T_MWB));

        // sw
        set_in(6'b101011, 6'b0, 1'b0);
        cyc("sw_fetch", ex(T_F));
        cyc("sw_decode", ex(T_D));
        cyc("sw_memadr", ex(T_MA));
        cyc("sw_memwr", ex(T_MW));

        // beq taken / not taken
        set_in(6'b000100, 6'b0, 1'b1);
        cyc("beq1_fetch", ex(T_F));
        cyc("beq1_decode", ex(T_D));
        cyc("beq1_branch", ex(T_BR, 3'b110, 1'b1));
        set_in(6'b000100, 6'b0, 1'b0);
        cyc("beq0_fetch", ex(T_F));
        cyc("beq0_decode", ex(T_D));
        cyc("beq0_branch", ex(T_BR, 3'b110, 1'b0));

        // R-type functs
        for (int i = 0; i < 5; i++) begin
            set_in(6'b000000, functs[i], 1'b0);
            cyc("r_fetch", ex(T_F));
            cyc("r_decode", ex(T_D));
            cyc("r_execute", ex(T_EX, aluexp[i]));
            cyc("r_aluwb", ex(T_AWB));
        end
        set_in(6'b000000, 6'b111111, 1'b0);
        cyc("rbad_fetch", ex(T_F));
        cyc("rbad_decode", ex(T_D));
        cyc("rbad_execute", ex(T_EX, 3'b010));
        cyc("rbad_aluwb", ex(T_AWB));

        // addi, j
        set_in(6'b001000, 6'b0, 1'b0);
        cyc("addi_fetch", ex(T_F));
        cyc("addi_decode", ex(T_D));
        cyc("addi_exec", ex(T_AE));
        cyc("addi_wb", ex(T_AIWB));
        set_in(6'b000010, 6'b0, 1'b0);
        cyc("j_fetch", ex(T_F));
        cyc("j_decode", ex(T_D));
        cyc("j_jump", ex(T_J));

        // unknown opcode
        set_in(6'b111111, 6'b0, 1'b0);
        cyc("unk_fetch", ex(T_F));
        cyc("unk_decode", ex(T_D, 3'b010, 1'b0, 1'b1));

        // bne with Zero=0
        set_in(6'b000101, 6'b0, 1'b0);
        cyc("bne_fetch", ex(T_F));
`ifdef MIPS_MC_BNE_EN
        cyc("bne_decode", ex(T_D));
        cyc("bne_branch", ex(T_BR, 3'b110, 1'b1));
`else
        cyc("bne_decode", ex(T_D, 3'b010, 1'b0, 1'b1));
`endif

        // reset dropped while in MEMWR
        set_in(6'b101011, 6'b0, 1'b0);
        cyc("swr_fetch", ex(T_F));
        cyc("swr_decode", ex(T_D));
        cyc("swr_memadr", ex(T_MA));
        rst_n = 1'b0;
        cyc("swr_reset_memwr", ex(T_RST));
        cyc("swr_reset_hold", ex(T_RST));
        rst_n = 1'b1;
        cyc("swr_refetch", ex(T_F));
        cyc("swr_redecode", ex(T_D));
        cyc("swr_rememadr", ex(T_MA));
        cyc("swr_rememwr", ex(T_MW));
        cyc("post_fetch", ex(T_F));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
